// File: rtl/control_unit.sv
// Hardwired control sequencer: fetches an instruction (T0-T2), decodes the opcode
// and walks the execute steps (T3-T6) that drive the datapath enables and bus selects.
module control_unit #(
    parameter int OPCODE_W  = 5,
    parameter int REG_IDX_W = 4,
    parameter int NUM_REGS  = 16
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic [31:0]           IR_Data,
    output logic [NUM_REGS-1:0]   r_enable,
    output logic [NUM_REGS-1:0]   r_select,
    output logic                  PC_select,
    output logic                  Z_LO_select,
    output logic                  Z_HI_select,
    output logic                  MDR_select,
    output logic                  HI_select,
    output logic                  LO_select,
    output logic                  c_select,
    output logic                  PC_enable,
    output logic                  PC_increment_enable,
    output logic                  IR_enable,
    output logic                  Y_enable,
    output logic                  Z_enable,
    output logic                  MAR_enable,
    output logic                  MDR_enable,
    output logic                  HI_enable,
    output logic                  LO_enable,
    output logic                  read,
    output logic [OPCODE_W-1:0]   alu_instruction,
    output logic                  run,
    output logic [3:0]            present_state
);

    typedef enum logic [3:0] {
        S_RST  = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_HALT = 4'd8
    } state_t;

    localparam logic [OPCODE_W-1:0] OP_R3_LAST  = OPCODE_W'(5'h0B);
    localparam logic [OPCODE_W-1:0] OP_IMM_LO   = OPCODE_W'(5'h0C);
    localparam logic [OPCODE_W-1:0] OP_IMM_HI   = OPCODE_W'(5'h0E);
    localparam logic [OPCODE_W-1:0] OP_MUL      = OPCODE_W'(5'h0F);
    localparam logic [OPCODE_W-1:0] OP_DIV      = OPCODE_W'(5'h10);
    localparam logic [OPCODE_W-1:0] OP_MFHI     = OPCODE_W'(5'h11);
    localparam logic [OPCODE_W-1:0] OP_MFLO     = OPCODE_W'(5'h12);
    localparam logic [OPCODE_W-1:0] OP_HALT     = OPCODE_W'(5'h1B);

    state_t state_q;
    state_t state_d;

    // Instruction fields
    logic [OPCODE_W-1:0]  op;
    logic [REG_IDX_W-1:0] ra_idx;
    logic [REG_IDX_W-1:0] rb_idx;
    logic [REG_IDX_W-1:0] rc_idx;
    logic [NUM_REGS-1:0]  ra_onehot;
    logic [NUM_REGS-1:0]  rb_onehot;
    logic [NUM_REGS-1:0]  rc_onehot;

    assign op     = IR_Data[31:31-OPCODE_W+1];
    assign ra_idx = IR_Data[26:26-REG_IDX_W+1];
    assign rb_idx = IR_Data[22:22-REG_IDX_W+1];
    assign rc_idx = IR_Data[18:18-REG_IDX_W+1];

    assign ra_onehot = NUM_REGS'(1) << ra_idx;
    assign rb_onehot = NUM_REGS'(1) << rb_idx;
    assign rc_onehot = NUM_REGS'(1) << rc_idx;

    // Instruction classes; anything not matched falls through as a NOP
    logic is_r3;
    logic is_imm;
    logic is_md;
    logic is_mfhi;
    logic is_mflo;
    logic is_halt;
    logic uses_alu;

    assign is_r3    = (op <= OP_R3_LAST);
    assign is_imm   = (op >= OP_IMM_LO) && (op <= OP_IMM_HI);
    assign is_md    = (op == OP_MUL) || (op == OP_DIV);
    assign is_mfhi  = (op == OP_MFHI);
    assign is_mflo  = (op == OP_MFLO);
    assign is_halt  = (op == OP_HALT);
    assign uses_alu = is_r3 || is_imm || is_md;

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= S_RST;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_RST: state_d = S_T0;
            S_T0:  state_d = S_T1;
            S_T1:  state_d = S_T2;
            S_T2:  state_d = S_T3;
            S_T3: begin
                if (uses_alu) begin
                    state_d = S_T4;
                end else if (is_halt) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_T0;
                end
            end
            S_T4: state_d = S_T5;
            S_T5: state_d = is_md ? S_T6 : S_T0;
            S_T6: state_d = S_T0;
            S_HALT: state_d = S_HALT;
            default: state_d = S_RST;
        endcase
    end

    // Output decode: every signal defaults low and only the active step raises it
    always_comb begin
        r_enable            = '0;
        r_select            = '0;
        PC_select           = 1'b0;
        Z_LO_select         = 1'b0;
        Z_HI_select         = 1'b0;
        MDR_select          = 1'b0;
        HI_select           = 1'b0;
        LO_select           = 1'b0;
        c_select            = 1'b0;
        PC_enable           = 1'b0;
        PC_increment_enable = 1'b0;
        IR_enable           = 1'b0;
        Y_enable            = 1'b0;
        Z_enable            = 1'b0;
        MAR_enable          = 1'b0;
        MDR_enable          = 1'b0;
        HI_enable           = 1'b0;
        LO_enable           = 1'b0;
        read                = 1'b0;
        alu_instruction     = '0;
        run                 = 1'b0;

        unique case (state_q)
            S_T0: begin
                run                 = 1'b1;
                PC_select           = 1'b1;
                MAR_enable          = 1'b1;
                PC_increment_enable = 1'b1;
                Z_enable            = 1'b1;
            end
            S_T1: begin
                run         = 1'b1;
                Z_LO_select = 1'b1;
                PC_enable   = 1'b1;
                read        = 1'b1;
                MDR_enable  = 1'b1;
            end
            S_T2: begin
                run        = 1'b1;
                MDR_select = 1'b1;
                IR_enable  = 1'b1;
            end
            S_T3: begin
                run = 1'b1;
                if (uses_alu) begin
                    r_select = rb_onehot;
                    Y_enable = 1'b1;
                end else if (is_mfhi) begin
                    HI_select = 1'b1;
                    r_enable  = ra_onehot;
                end else if (is_mflo) begin
                    LO_select = 1'b1;
                    r_enable  = ra_onehot;
                end
            end
            S_T4: begin
                run = 1'b1;
                if (uses_alu) begin
                    if (is_imm) begin
                        c_select = 1'b1;
                    end else begin
                        r_select = rc_onehot;
                    end
                    alu_instruction = op;
                    Z_enable        = 1'b1;
                end
            end
            S_T5: begin
                run = 1'b1;
                if (uses_alu) begin
                    Z_LO_select = 1'b1;
                    if (is_md) begin
                        LO_enable = 1'b1;
                    end else begin
                        r_enable = ra_onehot;
                    end
                end
            end
            S_T6: begin
                run         = 1'b1;
                Z_HI_select = 1'b1;
                HI_enable   = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign present_state = state_q;

endmodule
